// File: rtl/bios_request_unit.sv
// bios_request_unit: issues BIOS-class instructions to the BIOS bus and retires their responses
module bios_request_unit #(
    parameter int PC_TIMEOUT = 16,
    parameter int TMO_W      = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [7:0]  instr_opcode,
    input  logic [31:0] instr_operand,
    input  logic [4:0]  instr_rd,
    output logic        instr_ready,
    input  logic        pipe_retire,
    output logic [0:7]  processor_opcode_operation,
    output logic [31:0] processor_info,
    input  logic [31:0] bios_info,
    input  logic        write_process_pc,
    output logic        done_inst,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        pc_load,
    output logic [31:0] pc_load_value,
    output logic        stall,
    output logic        illegal_op
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP, WAITPC} state_t;
    typedef enum logic [1:0] {C_NONE, C_SINGLE, C_RESP, C_GRANT} cls_t;

    function automatic cls_t cls_of(input logic [7:0] op);
        return (op == 8'hB0 || op == 8'hB3) ? C_RESP :
               (op == 8'hB1 || op == 8'hB2 || op == 8'hB4 || op == 8'hB5 || op == 8'h01) ? C_SINGLE :
               (op == 8'h03) ? C_GRANT : C_NONE;
    endfunction

    state_t            state, state_n;
    logic [7:0]        op_q;
    logic [31:0]       opd_q;
    logic [4:0]        rd_q;
    logic [TMO_W-1:0]  cnt;
    logic              ill_q;
    cls_t              in_cls, q_cls;
    logic              grant, tmo, done_i;

    assign in_cls = cls_of(instr_opcode);
    assign q_cls  = cls_of(op_q);

    always_comb begin
        grant   = (state == WAITPC) && write_process_pc;
        tmo     = (state == WAITPC) && !write_process_pc && (cnt == TMO_W'(PC_TIMEOUT - 1));
        done_i  = ((state == ISSUE) && (q_cls == C_SINGLE)) || (state == RESP) || grant || tmo;
        state_n = state;
        case (state)
            IDLE:    state_n = (instr_valid && in_cls != C_NONE) ? ISSUE : IDLE;
            ISSUE:   state_n = (q_cls == C_RESP) ? RESP : (q_cls == C_GRANT) ? WAITPC : IDLE;
            RESP:    state_n = IDLE;
            default: state_n = (grant || tmo) ? IDLE : WAITPC;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= 8'h00;
            opd_q <= 32'd0;
            rd_q  <= 5'd0;
            cnt   <= '0;
            ill_q <= 1'b0;
        end else begin
            state <= state_n;
            ill_q <= (state == IDLE) && instr_valid && (in_cls == C_NONE);
            cnt   <= (state == ISSUE) ? '0 : (state == WAITPC) ? cnt + 1'b1 : cnt;
            if (state == IDLE && instr_valid && in_cls != C_NONE) begin
                op_q  <= instr_opcode;
                opd_q <= instr_operand;
                rd_q  <= instr_rd;
            end
        end
    end

    // Only SETQUANTUM and SETPC carry an operand onto the bus
    assign processor_opcode_operation = (state == ISSUE) ? op_q : 8'h00;
    assign processor_info = (state == ISSUE && (op_q == 8'hB4 || op_q == 8'h03)) ? opd_q : 32'd0;
    assign instr_ready    = (state == IDLE);
    assign stall          = (state != IDLE);
    assign done_inst      = pipe_retire || done_i;
    assign rf_we          = (state == RESP);
    assign rf_waddr       = rf_we ? rd_q : 5'd0;
    assign rf_wdata       = rf_we ? bios_info : 32'd0;
    assign pc_load        = grant;
    assign pc_load_value  = grant ? opd_q : 32'd0;
    assign illegal_op     = ill_q || tmo;
endmodule
